// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM states and flag bundle shared by alu_seq and its bench
package alu_pkg;
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_ANDN = 3'd4;
  localparam logic [2:0] OP_ORN  = 3'd5;
  localparam logic [2:0] OP_SUB  = 3'd6;
  localparam logic [2:0] OP_SLT  = 3'd7;
  typedef enum logic {IDLE, MUL} state_t;
  typedef struct packed {
    logic z;
    logic c;
    logic v;
    logic n;
  } flags_t;
endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add WIDTH x WIDTH multiplier, one partial product per cycle
module alu_seq_mul #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_prod
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  // o_prod is the product after this cycle's step, so it is final while o_done is high
  assign o_prod = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign o_done = r_busy && (r_cnt == CW'(WIDTH - 1));
  // operand latch on start, then one add/shift step per cycle for WIDTH cycles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_prod   <= '0;
      r_mplier <= i_b;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_prod   <= o_prod;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      r_busy   <= !o_done;
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready input, status flags, accumulator and iterative multiply
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  input  logic             use_acc,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_n,
  output logic [WIDTH-1:0] acc
);
  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_start;
  logic               w_wr;
  logic               w_mul_done;
  logic               r_pend;
  logic               r_out_valid;
  logic [2:0]         r_sel;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   w_opa;
  logic [WIDTH-1:0]   w_acc_fwd;
  logic [WIDTH-1:0]   w_res;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_dif;
  logic [2*WIDTH-1:0] w_prod;
  flags_t             w_flg;
  flags_t             r_flg;
  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_a     (w_opa),
    .i_b     (b),
    .o_done  (w_mul_done),
    .o_prod  (w_prod)
  );
  assign w_accept  = in_valid && in_ready;
  assign w_wr      = r_pend || w_mul_done;
  // a result landing this edge is forwarded so back-to-back accumulate ops see it
  assign w_acc_fwd = w_wr ? w_res : r_acc;
  assign w_opa     = use_acc ? (acc_clr ? '0 : w_acc_fwd) : a;
  assign w_sum     = {1'b0, r_opa} + {1'b0, r_b};
  assign w_dif     = {1'b0, r_opa} - {1'b0, r_b};
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  // next state, ready and multiplier start
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_start     = 1'b0;
    if (r_state == IDLE) begin
      in_ready    = 1'b1;
      w_start     = in_valid && (sel == OP_MUL);
      w_state_nxt = w_start ? MUL : IDLE;
    end else begin
      w_state_nxt = w_mul_done ? IDLE : MUL;
    end
  end
  // operand stage: single-cycle ops are computed the cycle after accept
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pend <= 1'b0;
      r_opa  <= '0;
      r_b    <= '0;
      r_sel  <= OP_AND;
    end else begin
      r_pend <= w_accept && (sel != OP_MUL);
      if (w_accept) begin
        r_opa <= w_opa;
        r_b   <= b;
        r_sel <= sel;
      end
    end
  // op decode and flags; a finishing multiply supplies the result when no single-cycle op is pending
  always_comb begin
    w_res = '0;
    w_flg = '0;
    if (!r_pend) begin
      w_res   = w_prod[WIDTH-1:0];
      w_flg.c = |w_prod[2*WIDTH-1:WIDTH];
    end else begin
      case (r_sel)
        OP_AND:  w_res = r_opa & r_b;
        OP_OR:   w_res = r_opa | r_b;
        OP_ANDN: w_res = r_opa & ~r_b;
        OP_ORN:  w_res = r_opa | ~r_b;
        OP_SLT:  w_res = WIDTH'(r_opa < r_b);
        OP_ADD: begin
          w_res   = w_sum[WIDTH-1:0];
          w_flg.c = w_sum[WIDTH];
          w_flg.v = (r_opa[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_opa[WIDTH-1]);
        end
        OP_SUB: begin
          w_res   = w_dif[WIDTH-1:0];
          w_flg.c = w_dif[WIDTH];
          w_flg.v = (r_opa[WIDTH-1] != r_b[WIDTH-1]) && (w_dif[WIDTH-1] != r_opa[WIDTH-1]);
        end
        default: w_res = '0;
      endcase
    end
    w_flg.z = (w_res == '0);
    w_flg.n = w_res[WIDTH-1];
  end
  // result, flags and the one-cycle out_valid pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_result    <= '0;
      r_flg       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_wr;
      if (w_wr) begin
        r_result <= w_res;
        r_flg    <= w_flg;
      end
    end
  // accumulator: a result write takes priority over a clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       r_acc <= '0;
    else if (w_wr)    r_acc <= w_res;
    else if (acc_clr) r_acc <= '0;
  assign result    = r_result;
  assign out_valid = r_out_valid;
  assign flag_z    = r_flg.z;
  assign flag_c    = r_flg.c;
  assign flag_v    = r_flg.v;
  assign flag_n    = r_flg.n;
  assign acc       = r_acc;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at WIDTH = 4
module tb_alu_seq;
  import alu_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] sel;
  logic       use_acc;
  logic       acc_clr;
  logic [3:0] result;
  logic       out_valid;
  logic       flag_z;
  logic       flag_c;
  logic       flag_v;
  logic       flag_n;
  logic [3:0] acc;
  int         errors = 0;
  int         checks = 0;
  logic [2:0] lsel [5] = '{OP_AND, OP_OR, OP_ANDN, OP_ORN, OP_SLT};
  logic [3:0] lres [5] = '{4'b0100, 4'b0111, 4'b0001, 4'b1101, 4'b0001};
  logic [3:0] exp_r;
  alu_seq #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .use_acc   (use_acc),
    .acc_clr   (acc_clr),
    .result    (result),
    .out_valid (out_valid),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_n    (flag_n),
    .acc       (acc)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [3:0] ta, input logic [3:0] tb, input logic [2:0] ts,
                       input logic tu, input logic tc);
    a = ta; b = tb; sel = ts; use_acc = tu; acc_clr = tc; in_valid = 1'b1;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_res"},   result, 0);
    chk({tag, "_flags"}, {flag_z, flag_c, flag_v, flag_n}, 4'b0000);
    chk({tag, "_ov"},    out_valid, 0);
    chk({tag, "_acc"},   acc, 0);
    chk({tag, "_ready"}, in_ready, 1);
  endtask
  initial begin
    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; sel = OP_AND; use_acc = 1'b0; acc_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    chk("rst_release_ov", out_valid, 0);
    drive(4'd5, 4'd6, OP_ADD, 1'b0, 1'b0);
    tick;
    chk("add_latency_ov", out_valid, 0);
    drive(4'd5, 4'd6, OP_SUB, 1'b0, 1'b0);
    tick;
    chk("add_res", result, 4'b1011);
    chk("add_flags_zcvn", {flag_z, flag_c, flag_v, flag_n}, 4'b0011);
    chk("add_ov", out_valid, 1);
    in_valid = 1'b0;
    tick;
    chk("sub_res", result, 4'b1111);
    chk("sub_flags_zcvn", {flag_z, flag_c, flag_v, flag_n}, 4'b0101);
    chk("sub_ov", out_valid, 1);
    tick;
    chk("sub_pulse_end", out_valid, 0);
    chk("sub_hold", result, 4'b1111);
    drive(4'b0101, 4'b0110, lsel[0], 1'b0, 1'b0);
    tick;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(4'b0101, 4'b0110, lsel[i+1], 1'b0, 1'b0);
      else in_valid = 1'b0;
      tick;
      exp_r = lres[i];
      chk($sformatf("logic%0d_res", i), result, exp_r);
      chk($sformatf("logic%0d_flags", i), {flag_z, flag_c, flag_v, flag_n}, {3'b000, exp_r[3]});
      chk($sformatf("logic%0d_ov", i), out_valid, 1);
    end
    drive(4'd5, 4'd6, OP_MUL, 1'b0, 1'b0);
    tick;
    chk("mul_busy_ready", in_ready, 0);
    drive(4'd1, 4'd1, OP_ADD, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick;
      chk($sformatf("mul_wait%0d_ov", i), out_valid, 0);
      chk($sformatf("mul_wait%0d_ready", i), in_ready, 0);
    end
    tick;
    chk("mul56_ov", out_valid, 1);
    chk("mul56_res", result, 4'b1110);
    chk("mul56_flags_zcvn", {flag_z, flag_c, flag_v, flag_n}, 4'b0101);
    chk("mul56_ready", in_ready, 1);
    in_valid = 1'b0;
    tick;
    chk("mul_ignored_ov", out_valid, 0);
    chk("mul_ignored_res", result, 4'b1110);
    drive(4'd3, 4'd2, OP_MUL, 1'b0, 1'b0);
    tick;
    in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick;
      chk($sformatf("mul32_wait%0d_ov", i), out_valid, 0);
    end
    tick;
    chk("mul32_ov", out_valid, 1);
    chk("mul32_res", result, 4'b0110);
    chk("mul32_flags_zcvn", {flag_z, flag_c, flag_v, flag_n}, 4'b0000);
    chk("mul32_acc", acc, 4'b0110);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    chk("acc_after_reset", acc, 0);
    drive(4'd0, 4'd1, OP_ADD, 1'b1, 1'b0);
    tick;
    for (int i = 1; i <= 17; i++) begin
      if (i == 17) in_valid = 1'b0;
      tick;
      chk($sformatf("acc_count%0d", i), acc, i % 16);
      chk($sformatf("acc_carry%0d", i), flag_c, i == 16);
      chk($sformatf("acc_ov%0d", i), out_valid, 1);
    end
    acc_clr = 1'b1;
    tick;
    acc_clr = 1'b0;
    chk("acc_clr_alone", acc, 0);
    drive(4'd5, 4'd6, OP_ADD, 1'b0, 1'b0);
    tick;
    in_valid = 1'b0;
    tick;
    chk("acc_load_b", acc, 4'b1011);
    drive(4'd0, 4'd3, OP_ADD, 1'b1, 1'b1);
    tick;
    in_valid = 1'b0;
    acc_clr = 1'b0;
    chk("acc_clr_accept_edge", acc, 0);
    tick;
    chk("acc_clr_use_res", result, 4'b0011);
    chk("acc_clr_use_acc", acc, 4'b0011);
    drive(4'd5, 4'd6, OP_MUL, 1'b0, 1'b0);
    tick;
    in_valid = 1'b0;
    tick;
    rst_n = 1'b0;
    #1 chk_all_zero("midmul_reset");
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk($sformatf("midmul_no_ov%0d", i), out_valid, 0);
    end
    chk("midmul_ready", in_ready, 1);
    chk("midmul_acc", acc, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
